// File: rtl/ttl_nport_reg_xcvr.sv
// N-port open-collector bus transceiver with holding register.
// One port sources; the others receive the live or stored word.
module ttl_nport_reg_xcvr #(
  parameter int WIDTH  = 4,
  parameter int PORTS  = 3,
  parameter int INVERT = 1,
  parameter int SELW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire [PORTS*WIDTH-1:0]  bus,
  input  logic [SELW-1:0]        sel,
  input  logic                   cs_n,
  input  logic [PORTS-1:0]       g_n,
  input  logic                   mode,
  input  logic                   ld,
  output logic                   qv
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] o;
  logic [PORTS-1:0] en;
  logic             sel_ok;

  assign sel_ok = 32'(sel) < PORTS;

  always_comb begin
    src = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (32'(sel) == p) src = bus[p*WIDTH +: WIDTH];
    end
  end

  assign d = mode ? q : src;
  assign o = (INVERT != 0) ? ~d : d;

  // Stored mode stays off the bus until something has been captured.
  always_comb begin
    en = '0;
    for (int p = 0; p < PORTS; p++) begin
      en[p] = !cs_n && sel_ok && (32'(sel) != p) &&
              !g_n[p] && (!mode || qv);
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign bus[p*WIDTH+b] = (en[p] && !o[b]) ? 1'b0 : 1'bz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (!cs_n && ld && sel_ok) begin
      q  <= src;
      qv <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ttl_nport_reg_xcvr.sv
// Bench for ttl_nport_reg_xcvr: inverting and non-inverting builds
// on pulled-up buses, directed plan steps then random traffic.
module tb_ttl_nport_reg_xcvr;

  logic        clk = 1'b0;
  logic        rst, cs_n, mode, ld;
  logic [1:0]  sel;
  logic [2:0]  g_n;
  logic        qv1, qv2;
  logic [2:0]  xe;
  logic [11:0] xv;
  wire  [11:0] bus1, bus2;

  int tests = 0;
  int fails = 0;

  logic [3:0] mq;
  logic       mqv;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 12; i++) begin : g_pu
    pullup (bus1[i]);
    pullup (bus2[i]);
    assign bus1[i] = (xe[i/4] && !xv[i]) ? 1'b0 : 1'bz;
    assign bus2[i] = (xe[i/4] && !xv[i]) ? 1'b0 : 1'bz;
  end

  ttl_nport_reg_xcvr #(.WIDTH(4), .PORTS(3), .INVERT(1), .SELW(2)) dut_inv (
    .clk(clk), .rst(rst), .bus(bus1), .sel(sel), .cs_n(cs_n),
    .g_n(g_n), .mode(mode), .ld(ld), .qv(qv1)
  );

  ttl_nport_reg_xcvr #(.WIDTH(4), .PORTS(3), .INVERT(0), .SELW(2)) dut_pos (
    .clk(clk), .rst(rst), .bus(bus2), .sel(sel), .cs_n(cs_n),
    .g_n(g_n), .mode(mode), .ld(ld), .qv(qv2)
  );

  // Value the outside world puts on port k (open collector, pulled up).
  function automatic logic [3:0] ext_read(int k);
    logic [3:0] v;
    v = 4'hF;
    if (xe[k]) v = xv[k*4 +: 4];
    return v;
  endfunction

  // Wired-AND of pullup, external driver and the device's drive.
  function automatic logic [3:0] exp_port(int p, bit inv);
    logic [3:0] d, o, v;
    bit en, ok;
    ok = int'(sel) < 3;
    d  = mode ? mq : (ok ? ext_read(int'(sel)) : 4'hF);
    o  = inv ? ~d : d;
    en = !cs_n && ok && (int'(sel) != p) && !g_n[p] && (!mode || mqv);
    v  = ext_read(p);
    if (en) v = v & o;
    return v;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    #2;
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s inv port%0d", tag, p), bus1[p*4 +: 4], exp_port(p, 1'b1));
      chk($sformatf("%s pos port%0d", tag, p), bus2[p*4 +: 4], exp_port(p, 1'b0));
    end
    chk($sformatf("%s qv inv", tag), {3'b0, qv1}, {3'b0, mqv});
    chk($sformatf("%s qv pos", tag), {3'b0, qv2}, {3'b0, mqv});
  endtask

  task automatic tick();
    bit cap;
    logic [3:0] s;
    cap = !cs_n && ld && (int'(sel) < 3);
    s   = (int'(sel) < 3) ? ext_read(int'(sel)) : 4'h0;
    @(posedge clk);
    if (rst) begin
      mq = 4'h0; mqv = 1'b0;
    end else if (cap) begin
      mq = s; mqv = 1'b1;
    end
    #1;
  endtask

  task automatic drive(int k, logic [3:0] v);
    xe[k] = 1'b1;
    xv[k*4 +: 4] = v;
  endtask

  initial begin
    mq = 4'h0; mqv = 1'b0;
    xe = 3'b000; xv = 12'hFFF;
    rst = 1'b1; cs_n = 1'b0; mode = 1'b1; ld = 1'b0;
    sel = 2'd0; g_n = 3'b000;
    @(negedge clk);
    tick();
    rst = 1'b0;
    check_all("reset");

    mode = 1'b0; g_n = 3'b001; drive(0, 4'b0001);
    check_all("realtime");
    g_n = 3'b101;
    check_all("realtime g_n");

    xe = 3'b000; sel = 2'd1; drive(1, 4'b0010); ld = 1'b1;
    tick();
    ld = 1'b0;
    check_all("capture");
    xe = 3'b000; mode = 1'b1; g_n = 3'b000;
    check_all("replay sel1");
    sel = 2'd2;
    check_all("replay sel2");

    cs_n = 1'b1;
    check_all("cs_n high");
    drive(1, 4'b0111); ld = 1'b1;
    tick();
    ld = 1'b0; xe = 3'b000; cs_n = 1'b0;
    check_all("cs_n ignores ld");
    sel = 2'd3;
    check_all("sel invalid");
    drive(1, 4'b0111); ld = 1'b1;
    tick();
    ld = 1'b0; xe = 3'b000;
    check_all("sel invalid ld");
    sel = 2'd2;
    check_all("stored kept");

    rst = 1'b1; ld = 1'b1; sel = 2'd1; drive(1, 4'b0000);
    tick();
    rst = 1'b0; ld = 1'b0; xe = 3'b000;
    check_all("reset over ld");

    mode = 1'b0; sel = 2'd2; g_n = 3'b000; drive(2, 4'b0100);
    check_all("noninv realtime");

    for (int i = 0; i < 80; i++) begin
      sel  = 2'($urandom_range(0, 3));
      cs_n = ($urandom_range(0, 5) == 0);
      g_n  = 3'($urandom);
      mode = 1'($urandom);
      ld   = 1'($urandom);
      rst  = ($urandom_range(0, 15) == 0);
      xe   = 3'b000;
      for (int k = 0; k < 3; k++) begin
        if (k == int'(sel) ? ($urandom_range(0, 3) != 0)
                           : ($urandom_range(0, 4) == 0))
          drive(k, 4'($urandom));
      end
      check_all($sformatf("rand%0d pre", i));
      tick();
      rst = 1'b0; ld = 1'b0;
      check_all($sformatf("rand%0d post", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
